// File: rtl/stopwatch_pkg.sv
// Purpose : shared types and constants for the stopwatch front-panel controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: run-control state encoding, default debounce count, time field width.
package stopwatch_pkg;

  // 10 ms at 50 MHz.
  localparam int DEBOUNCE_DEFAULT = 500_000;

  // mm and ss fields both hold 0..59.
  localparam int TIME_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_e;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Purpose : panel/counter bundle between board pins, stopwatch counter and controller.
// Latency : n/a (wiring only).
// Backpressure: none; commands are fire-and-forget single-cycle pulses.
// Signals : btn_ss/btn_lr raw buttons, sec_in/min_in live time, sw_start/sw_stop/sw_rst_n
//           counter commands, disp_sec/disp_min display time, state run-control state.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic              btn_ss;
  logic              btn_lr;
  logic [TIME_W-1:0] sec_in;
  logic [TIME_W-1:0] min_in;
  logic              sw_start;
  logic              sw_stop;
  logic              sw_rst_n;
  logic [TIME_W-1:0] disp_sec;
  logic [TIME_W-1:0] disp_min;
  logic [1:0]        state;

  // Board/counter side.
  modport master (
    output btn_ss, btn_lr, sec_in, min_in,
    input  sw_start, sw_stop, sw_rst_n, disp_sec, disp_min, state
  );

  // Controller side.
  modport slave (
    input  btn_ss, btn_lr, sec_in, min_in,
    output sw_start, sw_stop, sw_rst_n, disp_sec, disp_min, state
  );

endinterface

// File: rtl/btn_debounce.sv
// Purpose : synchronise, debounce and edge-detect one raw active-high push-button.
// Latency : raw edge to press_o = 2 sync + DEBOUNCE_CYCLES + 1 cycles.
// Backpressure: none; press_o is a one-cycle pulse per accepted press, releases are silent.
// Ports   : clk, rst_n (sync, active-low), btn_i raw async button, press_o press pulse.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            db_q;
  logic            db_prev_q;
  logic [DB_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      // Any sample that agrees with the accepted level restarts the count,
      // so bounce shorter than the window never gets through.
      if (sync2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES)) begin
        db_q  <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + DB_W'(1);
      end
    end
  end

  // Rising edge of the accepted level only.
  assign press_o = db_q & ~db_prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Purpose : front-panel run-control FSM issuing start/stop/clear to the counter and lap display.
// Latency : button event to state/command/display change 1 cycle; live display 1 cycle.
// Backpressure: none; counter must accept every single-cycle command pulse.
// Ports   : clk, rst_n (sync, active-low), bus (stopwatch_ctrl_if.slave) carrying buttons,
//           live time in, counter commands, display time and FSM state out.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  stopwatch_ctrl_if.slave   bus
);

  logic ss_evt;
  logic lr_evt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (bus.btn_ss),
    .press_o (ss_evt)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lr (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (bus.btn_lr),
    .press_o (lr_evt)
  );

  state_e            state_q;
  logic              sw_start_q;
  logic              sw_stop_q;
  logic              sw_rst_n_q;
  logic [TIME_W-1:0] disp_sec_q;
  logic [TIME_W-1:0] disp_min_q;
  logic [TIME_W-1:0] lap_sec_q;
  logic [TIME_W-1:0] lap_min_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sw_start_q <= 1'b0;
      sw_stop_q  <= 1'b0;
      // Held low through reset so the counter is cleared along with us.
      sw_rst_n_q <= 1'b0;
      disp_sec_q <= '0;
      disp_min_q <= '0;
      lap_sec_q  <= '0;
      lap_min_q  <= '0;
    end else begin
      sw_start_q <= 1'b0;
      sw_stop_q  <= 1'b0;
      sw_rst_n_q <= 1'b1;
      // Live time by default; only a held LAP state overrides this. On LAP
      // entry the live sample equals the value being captured, so the lap
      // value is already on the display in the cycle after the event.
      disp_sec_q <= bus.sec_in;
      disp_min_q <= bus.min_in;
      // ss is tested first in every state, so it wins over a same-cycle lr.
      case (state_q)
        IDLE: begin
          if (ss_evt) begin
            state_q    <= RUN;
            sw_start_q <= 1'b1;
          end else if (lr_evt) begin
            sw_rst_n_q <= 1'b0;
          end
        end
        RUN: begin
          if (ss_evt) begin
            state_q   <= PAUSE;
            sw_stop_q <= 1'b1;
          end else if (lr_evt) begin
            state_q   <= LAP;
            lap_sec_q <= bus.sec_in;
            lap_min_q <= bus.min_in;
          end
        end
        LAP: begin
          if (ss_evt) begin
            state_q   <= PAUSE;
            sw_stop_q <= 1'b1;
          end else if (lr_evt) begin
            state_q <= RUN;
          end else begin
            disp_sec_q <= lap_sec_q;
            disp_min_q <= lap_min_q;
          end
        end
        PAUSE: begin
          if (ss_evt) begin
            state_q    <= RUN;
            sw_start_q <= 1'b1;
          end else if (lr_evt) begin
            state_q    <= IDLE;
            sw_rst_n_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sw_start = sw_start_q;
  assign bus.sw_stop  = sw_stop_q;
  assign bus.sw_rst_n = sw_rst_n_q;
  assign bus.disp_sec = disp_sec_q;
  assign bus.disp_min = disp_min_q;
  assign bus.state    = state_q;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Front-panel controller for the mm:ss stopwatch counter. It debounces two raw push-buttons, start/stop and lap/reset, and runs a four-state run-control FSM. From that FSM it issues single-cycle start, stop and clear commands to the counter and selects live or frozen (lap) time for the display path. It sits between the board I/O pins and the stopwatch counter, in the same clock domain.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500_000, stable-sample count before a button level is accepted (10 ms at 50 MHz); legal range ≥ 1.
- DB_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, not overridden.

Ports:
- clk  in  1  system clock (50 MHz), single domain.
- rst_n  in  1  reset; synchronous, active-low.
- btn_ss  in  1  raw start/stop button, active-high, asynchronous to clk.
- btn_lr  in  1  raw lap/reset button, active-high, asynchronous to clk.
- sec_in  in  6  live seconds from the counter (0–59).
- min_in  in  6  live minutes from the counter (0–59).
- sw_start  out  1  one-cycle start command to the counter.
- sw_stop  out  1  one-cycle stop command to the counter.
- sw_rst_n  out  1  active-low clear to the counter; low for exactly one cycle per clear.
- disp_sec  out  6  seconds to display.
- disp_min  out  6  minutes to display.
- state  out  2  FSM state: IDLE=0, RUN=1, PAUSE=2, LAP=3.

## Operation
Button path, identical for each button:
- 2-flop synchronizer.
- Debounce: counter clears whenever the synced level equals the debounced level. It increments while the two differ. When it reaches DEBOUNCE_CYCLES, the debounced level takes the synced level and the counter clears.
- Press event: one-cycle pulse on a rising edge of the debounced level. Release produces no event.

FSM (ss = start/stop event, lr = lap/reset event):
- IDLE: ss → RUN, pulse sw_start. lr → stay IDLE, pulse clear (sw_rst_n low).
- RUN: ss → PAUSE, pulse sw_stop. lr → LAP, capture lap registers.
- LAP: ss → PAUSE, pulse sw_stop; the display returns to live. lr → RUN; the display returns to live.
- PAUSE: ss → RUN, pulse sw_start. lr → IDLE, pulse clear.
- ss and lr in the same cycle: ss wins and lr is discarded.
- sw_start and sw_stop are never asserted together. Neither is asserted in the same cycle as the sw_rst_n low pulse.

Display:
- In LAP, disp_* shows the lap registers. The lap registers hold the sec_in/min_in values sampled in the lr event cycle.
- In every other state, disp_* = sec_in/min_in registered with one cycle of delay.
- Lap registers are not cleared on leaving LAP. They are overwritten at the next capture.

Reset (rst_n low at a clock edge, any state):
- Next edge: state=IDLE, sw_start=0, sw_stop=0, sw_rst_n=0, disp_*=0, lap regs=0, synchronizer flops=0, debounced levels=0, debounce counters=0.
- sw_rst_n returns to 1 on the first edge with rst_n high. The counter is therefore cleared by the controller's reset.
- A button held through reset release is treated as a new press. It produces an event after the full debounce latency.

## Timing
- Raw edge to press event: 2 sync cycles + DEBOUNCE_CYCLES + 1 edge-detect cycle, ±1 for sampling phase.
- Event cycle N: state, sw_start/sw_stop/sw_rst_n and lap capture are registered at edge N+1, so all are visible in cycle N+1.
- Command pulses are 1 cycle wide.
- disp_* latency is 1 cycle for live time. In LAP, the lap value appears in cycle N+1.
- A glitch shorter than DEBOUNCE_CYCLES cycles of the synced level produces no event. Bounce restarts the counter.

## Structure
- Shared package stopwatch_pkg holds:
  - State encoding constants or enum: IDLE, RUN, PAUSE, LAP.
  - The default debounce count.
  - The time field width (6).
- Sub-module btn_debounce, instantiated twice. It contains the synchronizer, debounce counter and rising-edge pulse, with parameter DEBOUNCE_CYCLES.
- The top level contains the FSM, command pulse registers, lap registers and display mux.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: hold rst_n low 3 cycles → state=0, disp=0/0, sw_rst_n=0; sw_rst_n=1 one cycle after release.
- Bounce: btn_ss toggles every 2 cycles for 20 cycles, then releases → no event, state stays IDLE; a clean 10-cycle press → sw_start pulses once, state=RUN.
- Lap: in RUN, sec_in=23, min_in=4, press lr → state=LAP, disp=4:23 while sec_in advances to 30; press lr again → disp follows live time 1 cycle late, state=RUN.
- Pause/clear: RUN → ss gives sw_stop once, state=PAUSE; lr gives sw_rst_n low exactly 1 cycle, state=IDLE.
- Simultaneous: debounced events on both buttons in the same cycle in RUN → state=PAUSE, sw_stop pulses, lap registers unchanged.
- Reset mid-LAP with btn_ss held → IDLE next edge, all outputs at reset values; after release, one sw_start follows the debounce latency.
